// File: rtl/start_sequencer.sv
// rtl/start_sequencer.sv - timer start-up sequencer: power-up, GOJ, run, alarm, standby and single-step control
module start_sequencer #(
    parameter int PWR_CYC  = 16,
    parameter int GOJ_MCT  = 2,
    parameter int ALGA_MCT = 1
) (
    input  logic       CLOCK,
    input  logic       RESET_,
    input  logic       T12,
    input  logic       ALARM,
    input  logic       CMD_VALID,
    input  logic [2:0] CMD_OP,
    output logic       CMD_READY,
    output logic       SBY,
    output logic       ALGA,
    output logic       MSTRTP,
    output logic       STRT1,
    output logic       STRT2,
    output logic       GOJ1,
    output logic       MSTP,
    output logic       ERR,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_GOJ   = 3'd1,
        S_RUN   = 3'd2,
        S_ALRM  = 3'd3,
        S_STBY  = 3'd4,
        S_STEP  = 3'd5,
        S_STEPW = 3'd6
    } state_t;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_RESTART   = 3'd1;
    localparam logic [2:0] OP_SBY_ENTER = 3'd2;
    localparam logic [2:0] OP_SBY_EXIT  = 3'd3;
    localparam logic [2:0] OP_STEP_ON   = 3'd4;
    localparam logic [2:0] OP_STEP_OFF  = 3'd5;
    localparam logic [2:0] OP_STEP      = 3'd6;

    // Terminal counts: the transition fires on the cycle whose count equals N-1,
    // so the counter never exceeds 254 and cannot wrap.
    localparam logic [7:0] PWR_LAST  = 8'(PWR_CYC - 1);
    localparam logic [7:0] GOJ_LAST  = 8'(GOJ_MCT - 1);
    localparam logic [7:0] ALGA_LAST = 8'(ALGA_MCT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       t12_dly_q, t12_dly_d;
    logic       sby_q, sby_d;
    logic       alga_q, alga_d;
    logic       mstrtp_q, mstrtp_d;
    logic       strt1_q, strt1_d;
    logic       strt2_q, strt2_d;
    logic       goj1_q, goj1_d;
    logic       mstp_q, mstp_d;
    logic       err_q, err_d;
    logic       t12_edge;
    logic       cmd_acc;
    logic       restart;

    always_ff @(posedge CLOCK or negedge RESET_) begin
        if (!RESET_) begin
            state_q   <= S_PWRUP;
            cnt_q     <= 8'd0;
            t12_dly_q <= 1'b1;
            sby_q     <= 1'b0;
            alga_q    <= 1'b0;
            mstrtp_q  <= 1'b0;
            strt1_q   <= 1'b0;
            strt2_q   <= 1'b1;
            goj1_q    <= 1'b0;
            mstp_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            t12_dly_q <= t12_dly_d;
            sby_q     <= sby_d;
            alga_q    <= alga_d;
            mstrtp_q  <= mstrtp_d;
            strt1_q   <= strt1_d;
            strt2_q   <= strt2_d;
            goj1_q    <= goj1_d;
            mstp_q    <= mstp_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        restart   = 1'b0;
        t12_dly_d = T12;
        t12_edge  = T12 & ~t12_dly_q;
        CMD_READY = (state_q == S_RUN) || (state_q == S_STBY) || (state_q == S_STEP);
        cmd_acc   = CMD_VALID & CMD_READY;

        case (state_q)
            S_PWRUP: begin
                if (cnt_q >= PWR_LAST) state_d = S_GOJ;
                else                   cnt_d   = cnt_q + 8'd1;
            end
            S_GOJ: begin
                if (t12_edge) begin
                    if (cnt_q >= GOJ_LAST) state_d = S_RUN;
                    else                   cnt_d   = cnt_q + 8'd1;
                end
            end
            S_ALRM: begin
                if (t12_edge) begin
                    if (cnt_q >= ALGA_LAST) state_d = S_GOJ;
                    else                    cnt_d   = cnt_q + 8'd1;
                end
            end
            // ALARM pre-empts any command accepted in the same cycle; that command is dropped silently.
            S_RUN: begin
                if (ALARM) begin
                    state_d = S_ALRM;
                end else if (cmd_acc) begin
                    case (CMD_OP)
                        OP_NOP:       ;
                        OP_RESTART:   begin state_d = S_GOJ; restart = 1'b1; end
                        OP_SBY_ENTER: state_d = S_STBY;
                        OP_STEP_ON:   state_d = S_STEP;
                        default:      err_d = 1'b1;
                    endcase
                end
            end
            S_STBY: begin
                if (cmd_acc) begin
                    case (CMD_OP)
                        OP_NOP:      ;
                        OP_SBY_EXIT: state_d = S_PWRUP;
                        default:     err_d = 1'b1;
                    endcase
                end
            end
            S_STEP: begin
                if (ALARM) begin
                    state_d = S_ALRM;
                end else if (cmd_acc) begin
                    case (CMD_OP)
                        OP_NOP:      ;
                        OP_STEP:     state_d = S_STEPW;
                        OP_STEP_OFF: state_d = S_RUN;
                        default:     err_d = 1'b1;
                    endcase
                end
            end
            S_STEPW: begin
                if (ALARM)         state_d = S_ALRM;
                else if (t12_edge) state_d = S_STEP;
            end
            default: state_d = S_PWRUP;
        endcase

        if (state_d != state_q) cnt_d = 8'd0;

        // Outputs are decoded from the next state so they are registered yet aligned with STATE.
        strt2_d  = (state_d == S_PWRUP);
        goj1_d   = (state_d == S_GOJ);
        strt1_d  = restart;
        alga_d   = (state_d == S_ALRM);
        sby_d    = (state_d == S_STBY);
        mstp_d   = (state_d == S_STEP) || (state_d == S_STEPW);
        mstrtp_d = (state_d == S_STEPW) && (state_q != S_STEPW);
    end

    assign SBY    = sby_q;
    assign ALGA   = alga_q;
    assign MSTRTP = mstrtp_q;
    assign STRT1  = strt1_q;
    assign STRT2  = strt2_q;
    assign GOJ1   = goj1_q;
    assign MSTP   = mstp_q;
    assign ERR    = err_q;
    assign STATE  = state_q;

endmodule

// File: tb/tb_start_sequencer.sv
// tb/tb_start_sequencer.sv - directed-vector bench for start_sequencer
module tb_start_sequencer;

    logic       CLOCK = 1'b0;
    logic       RESET_;
    logic       T12;
    logic       ALARM;
    logic       CMD_VALID;
    logic [2:0] CMD_OP;
    logic       CMD_READY, SBY, ALGA, MSTRTP, STRT1, STRT2, GOJ1, MSTP, ERR;
    logic [2:0] STATE;

    int n_vec = 0;
    int n_bad = 0;

    start_sequencer dut (
        .CLOCK     (CLOCK),
        .RESET_    (RESET_),
        .T12       (T12),
        .ALARM     (ALARM),
        .CMD_VALID (CMD_VALID),
        .CMD_OP    (CMD_OP),
        .CMD_READY (CMD_READY),
        .SBY       (SBY),
        .ALGA      (ALGA),
        .MSTRTP    (MSTRTP),
        .STRT1     (STRT1),
        .STRT2     (STRT2),
        .GOJ1      (GOJ1),
        .MSTP      (MSTP),
        .ERR       (ERR),
        .STATE     (STATE)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic t12_pulse(input int gap);
        repeat (gap) @(negedge CLOCK);
        T12 = 1'b1;
        @(negedge CLOCK);
        T12 = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] op);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        @(negedge CLOCK);
        CMD_VALID = 1'b0;
        CMD_OP    = 3'd0;
    endtask

    task automatic count_strt2(input string tag);
        int n = 0;
        while (STRT2 && n < 100) begin
            n++;
            @(negedge CLOCK);
        end
        chk(tag, n, 16);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        RESET_ = 1'b0; T12 = 1'b0; ALARM = 1'b0; CMD_VALID = 1'b0; CMD_OP = 3'd0;
        repeat (3) @(negedge CLOCK);
        chk("rst_state", STATE, 0);
        chk("rst_strt2", STRT2, 1);
        chk("rst_goj1", GOJ1, 0);
        chk("rst_ready", CMD_READY, 0);
        chk("rst_err", ERR, 0);

        RESET_ = 1'b1;
        count_strt2("pwrup_len");
        chk("goj_state", STATE, 1);
        chk("goj_goj1", GOJ1, 1);
        t12_pulse(11);
        chk("goj_edge1_state", STATE, 1);
        t12_pulse(11);
        chk("run_state", STATE, 2);
        chk("run_goj1", GOJ1, 0);
        chk("run_ready", CMD_READY, 1);

        send_cmd(3'd4);
        chk("step_state", STATE, 5);
        chk("step_mstp", MSTP, 1);
        send_cmd(3'd6);
        chk("stepw_state", STATE, 6);
        chk("stepw_mstrtp", MSTRTP, 1);
        chk("stepw_ready", CMD_READY, 0);
        @(negedge CLOCK);
        chk("stepw_mstrtp_off", MSTRTP, 0);
        chk("stepw_hold", STATE, 6);
        t12_pulse(3);
        chk("stepw_to_step", STATE, 5);
        chk("step_mstp2", MSTP, 1);
        send_cmd(3'd6);
        T12 = 1'b1;
        @(negedge CLOCK);
        T12 = 1'b0;
        chk("stepw_same_edge", STATE, 5);
        send_cmd(3'd5);
        chk("stepoff_state", STATE, 2);
        chk("stepoff_mstp", MSTP, 0);

        send_cmd(3'd6);
        chk("run_illegal_err", ERR, 1);
        chk("run_illegal_state", STATE, 2);
        @(negedge CLOCK);
        chk("err_one_cycle", ERR, 0);
        send_cmd(3'd0);
        chk("nop_err", ERR, 0);
        chk("nop_state", STATE, 2);

        send_cmd(3'd2);
        chk("stby_state", STATE, 4);
        chk("stby_sby", SBY, 1);
        send_cmd(3'd7);
        chk("stby_op7_err", ERR, 1);
        chk("stby_op7_state", STATE, 4);
        ALARM = 1'b1;
        @(negedge CLOCK);
        ALARM = 1'b0;
        chk("stby_alarm_ignored", STATE, 4);
        send_cmd(3'd3);
        chk("sbyexit_state", STATE, 0);
        chk("sbyexit_sby", SBY, 0);
        count_strt2("sbyexit_pwrup_len");
        t12_pulse(3);
        t12_pulse(3);
        chk("sbyexit_run", STATE, 2);

        ALARM = 1'b1; CMD_VALID = 1'b1; CMD_OP = 3'd2;
        @(negedge CLOCK);
        ALARM = 1'b0; CMD_VALID = 1'b0; CMD_OP = 3'd0;
        chk("alarm_state", STATE, 3);
        chk("alarm_alga", ALGA, 1);
        chk("alarm_sby", SBY, 0);
        chk("alarm_err", ERR, 0);
        t12_pulse(3);
        chk("alrm_to_goj", STATE, 1);
        chk("alrm_alga_off", ALGA, 0);
        chk("alrm_goj1", GOJ1, 1);
        t12_pulse(3);
        t12_pulse(3);
        chk("alrm_run", STATE, 2);

        send_cmd(3'd4);
        ALARM = 1'b1;
        @(negedge CLOCK);
        ALARM = 1'b0;
        chk("step_alarm_state", STATE, 3);
        chk("step_alarm_mstp", MSTP, 0);
        t12_pulse(2);
        t12_pulse(2);
        t12_pulse(2);
        chk("step_alarm_run", STATE, 2);

        send_cmd(3'd1);
        chk("restart_state", STATE, 1);
        chk("restart_strt1", STRT1, 1);
        @(negedge CLOCK);
        chk("restart_strt1_off", STRT1, 0);
        chk("restart_goj1", GOJ1, 1);

        RESET_ = 1'b0;
        #2;
        chk("async_rst_state", STATE, 0);
        chk("async_rst_strt2", STRT2, 1);
        chk("async_rst_goj1", GOJ1, 0);
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET_ = 1'b1;
        count_strt2("rerelease_pwrup_len");
        T12 = 1'b1;
        repeat (5) @(negedge CLOCK);
        T12 = 1'b0;
        chk("held_t12_one_edge", STATE, 1);
        t12_pulse(3);
        chk("final_run", STATE, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/start_sequencer.md
START_SEQUENCER -- requirements
Module: start_sequencer

Interface
REQ-001 Parameter PWR_CYC, default 16: CLOCK cycles STRT2 is held after reset release or standby exit, legal range 1-255.
REQ-002 Parameter GOJ_MCT, default 2: T12 rising edges GOJ1 is held, legal range 1-255.
REQ-003 Parameter ALGA_MCT, default 1: T12 rising edges ALGA is held before GOJ, legal range 1-255.
REQ-004 CLOCK  input  1  sole clock; all state and outputs update on its rising edge.
REQ-005 RESET_  input  1  asynchronous, active-low reset.
REQ-006 T12  input  1  timer T12 level, synchronous to CLOCK, high for one or more cycles per MCT.
REQ-007 ALARM  input  1  level alarm request from alarm logic.
REQ-008 CMD_VALID  input  1  command present.
REQ-009 CMD_OP  input  3  opcode: 0 NOP, 1 RESTART, 2 SBY_ENTER, 3 SBY_EXIT, 4 STEP_ON, 5 STEP_OFF, 6 STEP, 7 reserved.
REQ-010 CMD_READY  output  1  command accepted this cycle when CMD_VALID is also high.
REQ-011 SBY, ALGA, MSTRTP, STRT1, STRT2, GOJ1, MSTP  output  1 each  timer control inputs.
REQ-012 ERR  output  1  one-cycle pulse on a rejected command.
REQ-013 STATE  output  3  current state encoding.

Function
REQ-014 States and encoding: PWRUP=0, GOJ=1, RUN=2, ALRM=3, STBY=4, STEP=5, STEPW=6.
REQ-015 All outputs are registered; no combinational path runs from any input to any output except CMD_READY, which is decoded from state.
REQ-016 T12 edge detect: registered T12 delay; the edge is asserted when T12 is 1 and the delayed T12 is 0; the delayed T12 resets to 1 so an already-high T12 at release does not count.
REQ-017 PWRUP: STRT2=1; counter counts CLOCK cycles; after PWR_CYC cycles the block goes to GOJ, and STRT2 is 0 from the first GOJ cycle.
REQ-018 GOJ: GOJ1=1; counter counts T12 edges; on the cycle after the GOJ_MCT-th edge the block goes to RUN.
REQ-019 ALRM: ALGA=1; after ALGA_MCT T12 edges the block goes to GOJ, and ALGA drops on GOJ entry.
REQ-020 RUN: all timer controls are 0.
REQ-021 RUN accepts RESTART -> GOJ with STRT1=1 for the first GOJ cycle only.
REQ-022 RUN accepts SBY_ENTER -> STBY and STEP_ON -> STEP.
REQ-023 STBY: SBY=1; SBY_EXIT -> PWRUP, where the counter reloads and SBY drops on PWRUP entry.
REQ-024 STEP: MSTP=1; STEP -> STEPW; STEP_OFF -> RUN, where MSTP drops on RUN entry.
REQ-025 STEPW: MSTP=1; MSTRTP=1 for the first STEPW cycle only; the next T12 edge -> STEP; the edge in the same cycle as MSTRTP counts.
REQ-026 CMD_READY=1 in RUN, STBY and STEP only.
REQ-027 A command is accepted when CMD_VALID=1 and CMD_READY=1.
REQ-028 CMD_OP is sampled only when a command is accepted.
REQ-029 An accepted NOP has no effect and raises no ERR.
REQ-030 An accepted opcode that is illegal in the current state, or opcode 7, leaves the state unchanged and pulses ERR on the following cycle.
REQ-031 ALARM sampled 1 in RUN, STEP or STEPW -> ALRM next cycle, with MSTP cleared.
REQ-032 ALARM is ignored in PWRUP, GOJ, ALRM and STBY.
REQ-033 ALARM and an accepted command in the same cycle: ALARM wins; the command is consumed and discarded without ERR.
REQ-034 Counter: 8-bit, cleared on every state entry, never wraps within a state.
REQ-035 Only one of STRT2, GOJ1, ALGA, SBY is ever 1 at a time.

Reset
REQ-036 While RESET_=0: STATE=PWRUP, STRT2=1, all other outputs 0, counter 0, delayed T12 1.
REQ-037 Reset assertion mid-operation in any state forces the REQ-036 values immediately, asynchronously.
REQ-038 After RESET_ release, the PWRUP sequence of REQ-017 restarts from count 0.

Verification
REQ-039 Reset release, T12 edge every 12 cycles -> STRT2 high 16 cycles; GOJ1 high until the cycle after the 2nd T12 edge; STATE=2; CMD_READY=1.
REQ-040 In RUN, CMD_OP=4 then CMD_OP=6 -> MSTP=1; MSTRTP one-cycle pulse; STATE 6 -> 5 at the next T12 edge; CMD_OP=5 -> MSTP=0, STATE=2.
REQ-041 In RUN, CMD_OP=6 -> ERR pulse one cycle later; STATE stays 2. CMD_OP=7 in STBY -> ERR; STATE stays 4.
REQ-042 ALARM=1 with CMD_OP=2 valid in the same cycle -> STATE=3; ALGA for 1 T12 edge; then GOJ1; SBY never 1; no ERR.
REQ-043 In STBY, CMD_OP=3 -> SBY=0 and STRT2=1 for 16 cycles, then GOJ -> RUN.
REQ-044 RESET_ pulled low mid-GOJ -> outputs take the REQ-036 values without waiting for a clock edge; after release, STRT2 is high for a full 16 cycles.
